// File: rtl/uart_word_packer.sv
// uart_word_packer: packs BYTES_PER_WORD bytes from uart_rx into one word.
// The first byte received lands in the MSB.
// A partial word is dropped if the gap between its bytes exceeds TIMEOUT_CYC.
// Each finished word is presented on a valid/ready handshake.
// Optional feature macro: PACKER_CHKSUM_EN.
// When it is defined, every word is followed by one XOR checksum byte.
module uart_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_CYC    = 2000,
  parameter int CNT_W          = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_data,
  input  logic                        po_flag,
  output logic [8*BYTES_PER_WORD-1:0] word_data,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        overflow,
  output logic                        frame_err,
  output logic                        chk_err
);
  localparam int N = BYTES_PER_WORD;
  localparam int W = 8*N;
`ifdef PACKER_CHKSUM_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif
  localparam int BC_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(FRAME-1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC-1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state, state_nxt;
  logic [BC_W-1:0]  byte_cnt, byte_cnt_nxt;
  logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
  logic [W-1:0]     shreg, shreg_nxt;
  logic [W-1:0]     word_asm;
  logic             frame_done, ferr_nxt, chk_ok, shift_en;
  logic             word_load, ovf_nxt, cerr_nxt;

`ifdef PACKER_CHKSUM_EN
  logic [7:0] xsum;

  // XOR of the data bytes collected so far; compared against the trailing byte.
  always_comb begin
    xsum = '0;
    for (int i = 0; i < N; i++) xsum = xsum ^ shreg[8*i +: 8];
  end

  // The checksum byte never enters the data register; the word is already complete.
  assign shift_en = (byte_cnt != LAST_BYTE);
  assign word_asm = shreg;
  assign chk_ok   = (xsum == rx_data);
`else
  assign shift_en = 1'b1;
  assign word_asm = {shreg[W-9:0], rx_data};
  assign chk_ok   = 1'b1;
`endif

  // Register the FSM state, the byte count, the gap timer and the byte shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      to_cnt   <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      to_cnt   <= to_cnt_nxt;
      shreg    <= shreg_nxt;
    end
  end

  // Next-state logic. A strobe always beats the timeout terminal cycle.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    to_cnt_nxt   = to_cnt;
    shreg_nxt    = shreg;
    frame_done   = 1'b0;
    ferr_nxt     = 1'b0;
    if (po_flag) begin
      to_cnt_nxt = '0;
      if (shift_en) shreg_nxt = {shreg[W-9:0], rx_data};
      if (byte_cnt == LAST_BYTE) begin
        frame_done   = 1'b1;
        byte_cnt_nxt = '0;
        state_nxt    = IDLE;
      end else begin
        byte_cnt_nxt = byte_cnt + 1'b1;
        state_nxt    = COLLECT;
      end
    end else if (state == COLLECT) begin
      if (to_cnt == TO_LAST) begin
        byte_cnt_nxt = '0;
        to_cnt_nxt   = '0;
        state_nxt    = IDLE;
        ferr_nxt     = 1'b1;
      end else begin
        to_cnt_nxt = to_cnt + 1'b1;
      end
    end
  end

  // A completed word loads if the holding register is empty or is being drained this cycle.
  assign word_load = frame_done & chk_ok & (~word_valid | word_ready);
  assign ovf_nxt   = frame_done & chk_ok & word_valid & ~word_ready;
  assign cerr_nxt  = frame_done & ~chk_ok;

  // Output holding register and the one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_data  <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      chk_err    <= 1'b0;
    end else begin
      overflow  <= ovf_nxt;
      frame_err <= ferr_nxt;
      chk_err   <= cerr_nxt;
      if (word_load) begin
        word_data  <= word_asm;
        word_valid <= 1'b1;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule
